// File: rtl/conv_window_sequencer.sv
// rtl/conv_window_sequencer.sv - raster pixel sequencer feeding a KxK line buffer with in-image window flags
`timescale 1ns/1ps
module conv_window_sequencer #(
    parameter int BITS        = 9,
    parameter int KERNEL_SIZE = 3,
    parameter int IMG_LENGTH  = 16,
    parameter int IMG_HEIGHT  = 16,
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1,
    localparam int CW = (IMG_LENGTH > 1) ? $clog2(IMG_LENGTH) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            pix_valid,
    input  logic [BITS-1:0] pix_in,
    output logic            pix_ready,
    output logic            sr_clear,
    output logic            sr_write_en,
    output logic [BITS-1:0] sr_data,
    input  logic            sr_ready,
    output logic            win_valid,
    input  logic            win_ready,
    output logic [RW-1:0]   win_row,
    output logic [CW-1:0]   win_col,
    output logic            busy,
    output logic            frame_done,
    output logic            seq_err
);

    // First row/column at which a full KxK window exists, and last raster position.
    localparam logic [RW-1:0] ROW_FIRST = RW'(KERNEL_SIZE - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(KERNEL_SIZE - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_LENGTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic            win_valid_q, win_valid_d;
    logic [RW-1:0]   win_row_q, win_row_d;
    logic [CW-1:0]   win_col_q, win_col_d;
    logic            frame_done_q, frame_done_d;
    logic            seq_err_q, seq_err_d;

    logic            accept;
    logic            qualify;
    logic            last_pix;

    // Handshake and buffer drive; an unconsumed window stalls the upstream stream.
    always_comb begin
        pix_ready   = (state_q == S_RUN) && (!win_valid_q || win_ready);
        accept      = pix_valid && pix_ready;
        sr_write_en = accept;
        sr_data     = accept ? pix_in : '0;
        sr_clear    = (state_q == S_CLEAR);
        busy        = (state_q != S_IDLE);
        qualify     = accept && (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
        last_pix    = accept && (row_q == ROW_LAST) && (col_q == COL_LAST);
    end

    // Next-state: frame FSM, raster counters and window tracking.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        win_valid_d  = win_valid_q;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        frame_done_d = 1'b0;
        seq_err_d    = seq_err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                row_d   = '0;
                col_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (last_pix) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!win_valid_q || win_ready) begin
                    state_d      = S_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        // A new window replaces the current one even when it is consumed this cycle.
        if (qualify) begin
            win_valid_d = 1'b1;
            win_row_d   = row_q - ROW_FIRST;
            win_col_d   = col_q - COL_FIRST;
            if (!sr_ready) begin
                seq_err_d = 1'b1;
            end
        end else if (win_valid_q && win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            win_valid_q  <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            frame_done_q <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            win_valid_q  <= win_valid_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            frame_done_q <= frame_done_d;
            seq_err_q    <= seq_err_d;
        end
    end

    assign win_valid  = win_valid_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign frame_done = frame_done_q;
    assign seq_err    = seq_err_q;

endmodule
